// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants and types for the segment-bus capture path.
package seg7_pkg;

  typedef logic [4:0] digit_t;

  localparam digit_t DIGIT_INVALID = 5'd31;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {SYNC, COLLECT, EMIT} scan_state_t;

  // One decoded sample as held by the per-position stability filter.
  typedef struct packed {
    logic   dp;
    digit_t digit;
    logic   err;
  } sample_t;

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational inverse segment decoder: 7-bit pattern (g..a) to digit 0..9 or DIGIT_INVALID.
module seg7_to_digit
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output digit_t     digit,
  output logic       err
);

  always_comb begin
    err = 1'b0;
    case (pattern)
      SEG_0:   digit = 5'd0;
      SEG_1:   digit = 5'd1;
      SEG_2:   digit = 5'd2;
      SEG_3:   digit = 5'd3;
      SEG_4:   digit = 5'd4;
      SEG_5:   digit = 5'd5;
      SEG_6:   digit = 5'd6;
      SEG_7:   digit = 5'd7;
      SEG_8:   digit = 5'd8;
      SEG_9:   digit = 5'd9;
      default: begin
        digit = DIGIT_INVALID;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers committed digits from a multiplexed 7-segment bus and pulses frame_valid per full frame.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode (inverted) seg_code buses.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              seg_code,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [5*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    sel_err,
  output logic                    frame_valid
);

  localparam int          PW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0]  STABLE = 4'(STABLE_CNT);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [7:0]            code_in;
  digit_t                lut_digit;
  logic                  lut_err;
  sample_t               sample;
  logic                  sel_multi;
  logic                  sample_vld;
  logic [PW-1:0]         pos;
  logic                  match;
  logic [3:0]            new_cnt;
  logic                  commit;
  logic [NUM_DIGITS-1:0] commit_vec;

  sample_t               cand_q [NUM_DIGITS];
  sample_t               cand_d [NUM_DIGITS];
  logic [3:0]            cnt_q  [NUM_DIGITS];
  logic [3:0]            cnt_d  [NUM_DIGITS];
  sample_t               out_q  [NUM_DIGITS];
  sample_t               out_d  [NUM_DIGITS];
  logic                  sel_err_q, sel_err_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  scan_state_t           state_q, state_d;

`ifdef SEG_ACTIVE_LOW_EN
  assign code_in = ~seg_code;
`else
  assign code_in = seg_code;
`endif

  // Only one position is sampled per cycle, so a single decoder is shared.
  seg7_to_digit u_lut (
    .pattern (code_in[6:0]),
    .digit   (lut_digit),
    .err     (lut_err)
  );

  assign sample     = '{dp: code_in[7], digit: lut_digit, err: lut_err};
  assign sel_multi  = (digit_sel & (digit_sel - SEL_ONE)) != '0;
  assign sample_vld = (digit_sel != '0) && !sel_multi;

  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel[i]) pos = PW'(i);
    end
  end

  // Commit fires only on the sample that brings the count up to STABLE, never while saturated.
  always_comb begin
    match   = (sample == cand_q[pos]);
    new_cnt = 4'd1;
    if (match) new_cnt = (cnt_q[pos] == STABLE) ? cnt_q[pos] : cnt_q[pos] + 4'd1;
    commit     = sample_vld && (new_cnt == STABLE) && !(match && cnt_q[pos] == STABLE);
    commit_vec = '0;
    if (commit) commit_vec[pos] = 1'b1;
  end

  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    sel_err_d = sel_err_q | sel_multi;
    if (sample_vld) begin
      cand_d[pos] = sample;
      cnt_d[pos]  = new_cnt;
    end
    if (commit) out_d[pos] = sample;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_q[i] <= '0;
        cnt_q[i]  <= '0;
        out_q[i]  <= '0;
      end
      sel_err_q <= 1'b0;
      mask_q    <= '0;
      state_q   <= SYNC;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      sel_err_q <= sel_err_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (sample_vld && pos == '0) state_d = COLLECT;
      COLLECT: if ((mask_q | commit_vec) == '1) state_d = EMIT;
      EMIT:    state_d = COLLECT;
      default: state_d = SYNC;
    endcase
  end

  // The aligning position-0 sample counts toward the frame; commits while unaligned do not.
  always_comb begin
    frame_valid = (state_q == EMIT);
    case (state_q)
      SYNC:    mask_d = (pos == '0) ? commit_vec : '0;
      COLLECT: mask_d = mask_q | commit_vec;
      EMIT:    mask_d = commit_vec;
      default: mask_d = '0;
    endcase
  end

  always_comb begin
    digits    = '0;
    dp        = '0;
    digit_err = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[5*i +: 5] = out_q[i].digit;
      dp[i]            = out_q[i].dp;
      digit_err[i]     = out_q[i].err;
    end
    sel_err = sel_err_q;
  end

endmodule
